// File: rtl/regfile_dump_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_dump_seq_pkg
//  Brief    : Shared types and widths for the register-file dump sequencer.
//  Revision : 1.0
// ============================================================================
package regfile_dump_seq_pkg;

    localparam int REG_IDX_W = 5;
    localparam int CNT_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_SEL   = 3'd2,
        ST_SEND  = 3'd3,
        ST_SUM   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage : regfile_dump_seq_pkg
`default_nettype wire

// File: rtl/regfile_dump_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_dump_seq_if
//  Brief    : Valid/ready output stream carrying dumped registers and checksum.
//  Revision : 1.0
// ============================================================================
interface regfile_dump_seq_if #(
    parameter int XLEN = 32
) ();

    logic                                        out_valid;
    logic                                        out_ready;
    logic [regfile_dump_seq_pkg::REG_IDX_W-1:0]  out_idx;
    logic [XLEN-1:0]                             out_data;
    logic                                        out_last;

    modport master (
        output out_valid,
        output out_idx,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        input  out_data,
        input  out_last,
        output out_ready
    );

endinterface : regfile_dump_seq_if
`default_nettype wire

// File: rtl/regfile_dump_seq.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_dump_seq
//  Brief    : Halts the CPU, walks reg_sel over the register file, streams each
//             value plus a final additive checksum, then releases the CPU.
//  Revision : 1.0
// ============================================================================
module regfile_dump_seq
    import regfile_dump_seq_pkg::*;
#(
    parameter int NREGS     = 32,
    parameter int XLEN      = 32,
    parameter int RD_LAT    = 1,
    parameter int DRAIN_CYC = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rstn,
    input  wire logic                  start,
    output logic                       busy,
    output logic                       cpu_halt,
    output logic [REG_IDX_W-1:0]       reg_sel,
    input  wire logic [XLEN-1:0]       reg_data,
    regfile_dump_seq_if.master         out_if,
    output logic                       done
);

    localparam logic [CNT_W-1:0]     c_DRAIN_LOAD = CNT_W'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0]     c_LAT_LOAD   = CNT_W'(RD_LAT);
    localparam logic [REG_IDX_W-1:0] c_LAST_IDX   = REG_IDX_W'(NREGS - 1);

    state_t                 r_state,  w_state_nxt;
    logic [CNT_W-1:0]       r_cnt,    w_cnt_nxt;
    logic [REG_IDX_W-1:0]   r_idx,    w_idx_nxt;
    logic [REG_IDX_W-1:0]   r_sel,    w_sel_nxt;
    logic [XLEN-1:0]        r_acc,    w_acc_nxt;
    logic                   r_valid,  w_valid_nxt;
    logic                   r_last,   w_last_nxt;
    logic [REG_IDX_W-1:0]   r_oidx,   w_oidx_nxt;
    logic [XLEN-1:0]        r_odata,  w_odata_nxt;
    logic                   w_xfer;

    assign w_xfer = r_valid && out_if.out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_sel   <= '0;
            r_acc   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_oidx  <= '0;
            r_odata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_sel   <= w_sel_nxt;
            r_acc   <= w_acc_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            r_oidx  <= w_oidx_nxt;
            r_odata <= w_odata_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_sel_nxt   = r_sel;
        w_acc_nxt   = r_acc;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;
        w_oidx_nxt  = r_oidx;
        w_odata_nxt = r_odata;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_DRAIN;
                    w_cnt_nxt   = c_DRAIN_LOAD;
                    w_idx_nxt   = '0;
                end
            end
            ST_DRAIN: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_sel_nxt   = r_idx;
                    w_cnt_nxt   = c_LAT_LOAD;
                    w_state_nxt = ST_SEL;
                end
            end
            ST_SEL: begin
                // Counter expiry marks reg_data as settled for the current reg_sel.
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_odata_nxt = reg_data;
                    w_oidx_nxt  = r_idx;
                    w_valid_nxt = 1'b1;
                    w_acc_nxt   = r_acc + reg_data;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_xfer) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_odata_nxt = r_acc;
                        w_oidx_nxt  = '0;
                        w_last_nxt  = 1'b1;
                        w_state_nxt = ST_SUM;
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_idx_nxt   = r_idx + REG_IDX_W'(1);
                        w_sel_nxt   = r_idx + REG_IDX_W'(1);
                        w_cnt_nxt   = c_LAT_LOAD;
                        w_state_nxt = ST_SEL;
                    end
                end
            end
            ST_SUM: begin
                if (w_xfer) begin
                    w_valid_nxt = 1'b0;
                    w_last_nxt  = 1'b0;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_acc_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Halt and busy span every non-idle state, including the one-cycle DONE.
    assign busy             = (r_state != ST_IDLE);
    assign cpu_halt         = (r_state != ST_IDLE);
    assign done             = (r_state == ST_DONE);
    assign reg_sel          = r_sel;
    assign out_if.out_valid = r_valid;
    assign out_if.out_idx   = r_oidx;
    assign out_if.out_data  = r_odata;
    assign out_if.out_last  = r_last;

endmodule : regfile_dump_seq
`default_nettype wire

// File: tb/tb_regfile_dump_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_dump_seq
//  Brief    : Scoreboard bench for regfile_dump_seq with a latency-1 register model.
//  Revision : 1.0
// ============================================================================
module tb_regfile_dump_seq;
    import regfile_dump_seq_pkg::*;

    localparam int NREGS     = 32;
    localparam int XLEN      = 32;
    localparam int RD_LAT    = 1;
    localparam int DRAIN_CYC = 4;

    logic             clk   = 1'b0;
    logic             rstn  = 1'b0;
    logic             start = 1'b0;
    logic             busy;
    logic             cpu_halt;
    logic [4:0]       reg_sel;
    logic [XLEN-1:0]  reg_data;
    logic             done;

    regfile_dump_seq_if #(.XLEN(XLEN)) out_if ();

    regfile_dump_seq #(
        .NREGS     (NREGS),
        .XLEN      (XLEN),
        .RD_LAT    (RD_LAT),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .busy     (busy),
        .cpu_halt (cpu_halt),
        .reg_sel  (reg_sel),
        .reg_data (reg_data),
        .out_if   (out_if),
        .done     (done)
    );

    always #5 clk = ~clk;

    // CPU register model: one registered stage between reg_sel and reg_data
    logic [XLEN-1:0] regs [NREGS];
    logic [4:0]      sel_d = '0;
    always @(posedge clk) sel_d <= reg_sel;
    assign reg_data = regs[sel_d];

    typedef struct packed {
        logic [4:0]      idx;
        logic [XLEN-1:0] data;
        logic            last;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0, n_err = 0, cyc = 0, beat_cnt = 0, done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Stream monitor: scoreboard pops on transfer, stability while stalled
    logic       prev_hold = 1'b0;
    logic       prev_valid = 1'b0;
    beat_t      prev_beat;
    logic [4:0] prev_sel;
    always @(negedge clk) begin
        beat_t got, e;
        got = '{idx: out_if.out_idx, data: out_if.out_data, last: out_if.out_last};
        if (!rstn) begin
            prev_hold  = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (prev_hold) begin
                n_cmp++;
                if (out_if.out_valid !== 1'b1 || got !== prev_beat) begin
                    n_err++;
                    $display("FAIL hold_stable: got v=%b %h expected v=1 %h", out_if.out_valid, got, prev_beat);
                end
            end
            if (prev_valid && out_if.out_valid) begin
                n_cmp++;
                if (reg_sel !== prev_sel) begin
                    n_err++;
                    $display("FAIL reg_sel_stable: got %0d expected %0d", reg_sel, prev_sel);
                end
            end
            if (out_if.out_valid && out_if.out_ready) begin
                beat_cnt++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL beat_unexpected: got %h expected none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_err++;
                        $display("FAIL beat: got idx=%0d data=%h last=%b expected idx=%0d data=%h last=%b",
                                 got.idx, got.data, got.last, e.idx, e.data, e.last);
                    end
                end
            end
            prev_hold  = out_if.out_valid && !out_if.out_ready;
            prev_valid = out_if.out_valid;
            prev_beat  = got;
            prev_sel   = reg_sel;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_dump();
        logic [XLEN-1:0] sum = '0;
        for (int i = 0; i < NREGS; i++) begin
            exp_q.push_back('{idx: 5'(i), data: regs[i], last: 1'b0});
            sum = sum + regs[i];
        end
        exp_q.push_back('{idx: 5'd0, data: sum, last: 1'b1});
        beat_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic pulse_start(output int t0);
        start = 1'b1;
        @(posedge clk);
        #1;
        t0    = cyc;
        start = 1'b0;
    endtask

    task automatic finish_dump(input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!busy && done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL %s_timeout: got busy=%b expected 0", name, busy); end
        n_cmp++;
        if (done_cnt !== 1) begin n_err++; $display("FAIL %s_done_count: got %0d expected 1", name, done_cnt); end
        n_cmp++;
        if (beat_cnt !== NREGS + 1) begin n_err++; $display("FAIL %s_beats: got %0d expected %0d", name, beat_cnt, NREGS + 1); end
        n_cmp++;
        if (exp_q.size() !== 0) begin n_err++; $display("FAIL %s_leftover: got %0d expected 0", name, exp_q.size()); end
    endtask

    task automatic test_reset();
        logic [47:0] outs;
        rstn = 1'b0;
        out_if.out_ready = 1'b1;
        repeat (3) tick();
        outs = {busy, cpu_halt, done, reg_sel, out_if.out_valid, out_if.out_last, out_if.out_idx, out_if.out_data};
        n_cmp++;
        if (outs !== '0) begin n_err++; $display("FAIL reset_outputs: got %h expected 0", outs); end
        rstn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            outs = {busy, cpu_halt, done, reg_sel, out_if.out_valid, out_if.out_last, out_if.out_idx, out_if.out_data};
            n_cmp++;
            if (outs !== '0) begin n_err++; $display("FAIL idle_outputs: got %h expected 0 at cycle %0d", outs, k); end
        end
    endtask

    task automatic test_basic();
        int t0, first_lat = -1, done_t = -1, n_valid = 0, prev_t = -1;
        bit halt_low_after = 1'b0, spacing_ok = 1'b1;
        for (int i = 0; i < NREGS; i++) regs[i] = XLEN'(i);
        push_dump();
        n_cmp++;
        if (cpu_halt !== 1'b0) begin n_err++; $display("FAIL pre_start_halt: got %b expected 0", cpu_halt); end
        pulse_start(t0);
        n_cmp++;
        if ({cpu_halt, busy} !== 2'b11) begin n_err++; $display("FAIL halt_after_start: got %b expected 11", {cpu_halt, busy}); end
        for (int k = 0; k < 300; k++) begin
            tick();
            if (out_if.out_valid) begin
                if (first_lat < 0) first_lat = cyc - t0;
                if (prev_t >= 0) begin
                    if (n_valid < NREGS && (cyc - prev_t) != RD_LAT + 2) spacing_ok = 1'b0;
                    if (n_valid == NREGS && (cyc - prev_t) != 1) spacing_ok = 1'b0;
                end
                prev_t = cyc;
                n_valid++;
            end
            if (done) done_t = cyc;
            if (done_t >= 0 && !done) begin
                halt_low_after = !cpu_halt && (cyc == done_t + 1);
                break;
            end
        end
        n_cmp++;
        if (first_lat !== DRAIN_CYC + RD_LAT + 1) begin n_err++; $display("FAIL first_beat_latency: got %0d expected %0d", first_lat, DRAIN_CYC + RD_LAT + 1); end
        n_cmp++;
        if (n_valid !== NREGS + 1) begin n_err++; $display("FAIL valid_cycles: got %0d expected %0d", n_valid, NREGS + 1); end
        n_cmp++;
        if (!spacing_ok) begin n_err++; $display("FAIL beat_spacing: got irregular expected %0d/1", RD_LAT + 2); end
        n_cmp++;
        if (done_t !== prev_t + 1) begin n_err++; $display("FAIL done_timing: got %0d expected %0d", done_t, prev_t + 1); end
        n_cmp++;
        if (!halt_low_after) begin n_err++; $display("FAIL halt_release: got halt=%b expected 0 after done", cpu_halt); end
        finish_dump("basic");
    endtask

    task automatic test_backpressure();
        int t0;
        bit found = 1'b0;
        for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
        regs[5] = 32'hDEADBEEF;
        push_dump();
        pulse_start(t0);
        for (int k = 0; k < 100 && !found; k++) begin
            if (reg_sel == 5'd5 && !out_if.out_valid) found = 1'b1;
            else tick();
        end
        out_if.out_ready = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (out_if.out_valid) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin n_err++; $display("FAIL bp_no_valid: got 0 expected 1"); end
        for (int k = 0; k < 7; k++) begin
            n_cmp++;
            if ({out_if.out_valid, out_if.out_idx, reg_sel, out_if.out_data} !== {1'b1, 5'd5, 5'd5, 32'hDEADBEEF}) begin
                n_err++;
                $display("FAIL bp_stall: got v=%b idx=%0d sel=%0d data=%h expected v=1 idx=5 sel=5 data=deadbeef",
                         out_if.out_valid, out_if.out_idx, reg_sel, out_if.out_data);
            end
            tick();
        end
        out_if.out_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (out_if.out_valid) found = 1'b1;
        end
        n_cmp++;
        if (out_if.out_idx !== 5'd6) begin n_err++; $display("FAIL bp_next_idx: got %0d expected 6", out_if.out_idx); end
        finish_dump("backpressure");
    endtask

    task automatic test_wrap();
        int t0;
        for (int i = 0; i < NREGS; i++) regs[i] = 32'h80000001;
        push_dump();
        pulse_start(t0);
        finish_dump("wrap");
    endtask

    task automatic test_start_busy();
        int  t0;
        bit  found = 1'b0;
        for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
        push_dump();
        pulse_start(t0);
        for (int k = 0; k < 100 && !found; k++) begin
            if (reg_sel == 5'd10 && !out_if.out_valid) found = 1'b1;
            else tick();
        end
        n_cmp++;
        if (!found) begin n_err++; $display("FAIL busy_reach_sel10: got sel=%0d expected 10", reg_sel); end
        pulse_start(t0);
        finish_dump("start_busy");
        repeat (5) tick();
        n_cmp++;
        if ({busy, cpu_halt} !== 2'b00) begin n_err++; $display("FAIL start_not_queued: got %b expected 00", {busy, cpu_halt}); end
    endtask

    task automatic test_reset_mid();
        int  t0;
        bit  found = 1'b0;
        for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
        push_dump();
        pulse_start(t0);
        for (int k = 0; k < 100 && !found; k++) begin
            if (out_if.out_valid && out_if.out_idx == 5'd12) found = 1'b1;
            else tick();
        end
        out_if.out_ready = 1'b0;
        tick();
        n_cmp++;
        if (!found || !out_if.out_valid) begin n_err++; $display("FAIL mid_reach_send12: got v=%b expected 1", out_if.out_valid); end
        #2 rstn = 1'b0;
        #1;
        n_cmp++;
        if ({cpu_halt, out_if.out_valid, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL async_reset: got %b expected 000", {cpu_halt, out_if.out_valid, busy});
        end
        exp_q.delete();
        repeat (2) tick();
        rstn = 1'b1;
        out_if.out_ready = 1'b1;
        tick();
        for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
        push_dump();
        pulse_start(t0);
        finish_dump("after_reset");
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) regs[i] = '0;
        out_if.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_start_busy();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_regfile_dump_seq
`default_nettype wire
